// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// The MemOp codes are the ones the core drives on its data port.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grantee_t;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and RAM port seen by the arbiter.
// The slave modport is the arbiter side; master is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_memop;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_memop;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_memop, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_memop, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_memop, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_memop, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on contention the requester
// that did not win last time is chosen. grant[0] = a, grant[1] = b.
module rr_pick2 (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last,
  output logic [1:0] grant
);

  // last = 1 means b was granted most recently.
  always_comb begin
    grant = 2'b00;
    if (req_a && req_b) begin
      grant = last ? 2'b01 : 2'b10;
    end else if (req_a) begin
      grant = 2'b01;
    end else if (req_b) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and
// data ports, one latched transaction at a time, with alternating priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  grantee_t          gnt_q;
  grantee_t          last_grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        memop_q;
  logic [1:0]        lat_cnt;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [1:0]        pick;
  logic              grant_any;
  logic              grant_d;
  logic              rd_capture;

  rr_pick2 u_pick (
    .req_a (bus.if_req),
    .req_b (bus.d_req),
    .last  (last_grant == GNT_D),
    .grant (pick)
  );

  assign grant_any  = |pick;
  assign grant_d    = pick[1];
  assign rd_capture = (state == WAIT) && (lat_cnt == 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Requests are only looked at in IDLE, so a req still high during DONE
  // cannot trigger a second grant.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_any) state_nxt = ACCESS;
      ACCESS:  state_nxt = we_q ? DONE : WAIT;
      WAIT:    if (lat_cnt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en = (state == ACCESS);
    bus.mem_we = (state == ACCESS) && we_q;
    bus.if_ack = (state == DONE) && (gnt_q == GNT_IF);
    bus.d_ack  = (state == DONE) && (gnt_q == GNT_D);
    bus.busy   = (state != IDLE);
  end

  // Transaction latch, latency counter and read-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q      <= GNT_IF;
      last_grant <= GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      memop_q    <= 3'b000;
      lat_cnt    <= 2'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if ((state == IDLE) && grant_any) begin
        if (grant_d) begin
          addr_q     <= bus.d_addr;
          wdata_q    <= bus.d_wdata;
          memop_q    <= bus.d_memop;
          we_q       <= bus.d_we;
          gnt_q      <= GNT_D;
          last_grant <= GNT_D;
        end else begin
          addr_q     <= bus.if_addr;
          memop_q    <= MEMOP_LW;
          we_q       <= 1'b0;
          gnt_q      <= GNT_IF;
          last_grant <= GNT_IF;
        end
      end
      if (state == ACCESS) begin
        lat_cnt <= LAT_INIT;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (rd_capture) begin
        if (gnt_q == GNT_D) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          if_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_memop = memop_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with MEM_LAT=1 and
// one with MEM_LAT=3, each attached to a small behavioural RAM.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  memop;
    int          cyc;
  } mexp_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } aexp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;
  int   en_count = 0;
  int   ack_count = 0;

  mexp_t mq[$];
  aexp_t ifq[$];
  aexp_t dq[$];
  aexp_t d3q[$];
  bit    ack_log[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3)) u_dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  // RAM models: data appears exactly MEM_LAT cycles after the mem_en cycle,
  // a garbage pattern otherwise.
  logic [31:0] ram1 [256];
  logic [31:0] rpipe1;
  logic [31:0] ram3 [256];
  logic [31:0] rpipe3 [3];

  always @(posedge clock) begin
    if (reset) begin
      ram1[8'h04] <= 32'h0050_0093;
      ram1[8'h80] <= 32'h1234_5678;
    end else if (bus1.mem_en && bus1.mem_we) begin
      ram1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
    end
    rpipe1 <= (bus1.mem_en && !bus1.mem_we) ? ram1[bus1.mem_addr[9:2]] : 32'hBAD0_BAD0;
  end
  assign bus1.mem_rdata = rpipe1;

  always @(posedge clock) begin
    if (reset) begin
      ram3[8'h80] <= 32'h1234_5678;
    end else if (bus3.mem_en && bus3.mem_we) begin
      ram3[bus3.mem_addr[9:2]] <= bus3.mem_wdata;
    end
    rpipe3[0] <= (bus3.mem_en && !bus3.mem_we) ? ram3[bus3.mem_addr[9:2]] : 32'hBAD0_BAD0;
    rpipe3[1] <= rpipe3[0];
    rpipe3[2] <= rpipe3[1];
  end
  assign bus3.mem_rdata = rpipe3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Monitor: pops expectations whenever the DUT shows an access or an ack.
  initial begin
    bit    prev_en;
    mexp_t m;
    aexp_t a;
    prev_en = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_en = 1'b0;
      end else begin
        check1("two_acks_same_cycle", bus1.if_ack & bus1.d_ack, 1'b0);
        check1("mem_en_back_to_back", bus1.mem_en & prev_en, 1'b0);
        check1("mem_we_without_en", bus1.mem_we & !bus1.mem_en, 1'b0);
        if (bus1.mem_en) begin
          en_count++;
          check1("mem_en_expected", mq.size() > 0, 1'b1);
          if (mq.size() > 0) begin
            m = mq.pop_front();
            check("mem_addr", bus1.mem_addr, m.addr);
            check1("mem_we", bus1.mem_we, m.we);
            check("mem_memop", 32'(bus1.mem_memop), 32'(m.memop));
            if (m.we) check("mem_wdata", bus1.mem_wdata, m.wdata);
            if (m.cyc >= 0) check("mem_en_cycle", 32'(cyc), 32'(m.cyc));
            check1("busy_in_access", bus1.busy, 1'b1);
          end
        end
        if (bus1.if_ack) begin
          ack_count++;
          ack_log.push_back(1'b0);
          check1("if_ack_expected", ifq.size() > 0, 1'b1);
          if (ifq.size() > 0) begin
            a = ifq.pop_front();
            check("if_rdata", bus1.if_rdata, a.data);
            if (a.cyc >= 0) check("if_ack_cycle", 32'(cyc), 32'(a.cyc));
          end
        end
        if (bus1.d_ack) begin
          ack_count++;
          ack_log.push_back(1'b1);
          check1("d_ack_expected", dq.size() > 0, 1'b1);
          if (dq.size() > 0) begin
            a = dq.pop_front();
            check("d_rdata", bus1.d_rdata, a.data);
            if (a.cyc >= 0) check("d_ack_cycle", 32'(cyc), 32'(a.cyc));
          end
        end
        check1("lat3_if_ack", bus3.if_ack, 1'b0);
        if (bus3.d_ack) begin
          check1("lat3_d_ack_expected", d3q.size() > 0, 1'b1);
          if (d3q.size() > 0) begin
            a = d3q.pop_front();
            check("lat3_d_rdata", bus3.d_rdata, a.data);
            check("lat3_d_ack_cycle", 32'(cyc), 32'(a.cyc));
          end
        end
        prev_en = bus1.mem_en;
      end
    end
  end

  task automatic wait_ack(input bit is_d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (is_d ? bus1.d_ack : bus1.if_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_mem(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [2:0] memop, input int c);
    mexp_t m;
    m.addr = addr; m.we = we; m.wdata = wdata; m.memop = memop; m.cyc = c;
    mq.push_back(m);
  endtask

  task automatic push_ack(input bit is_d, input logic [31:0] data, input int c);
    aexp_t a;
    a.data = data; a.cyc = c;
    if (is_d) dq.push_back(a);
    else ifq.push_back(a);
  endtask

  // Requester holds req through its ack cycle and drops it just after.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data);
    bit ok;
    @(negedge clock);
    push_mem(addr, 1'b0, 32'h0, MEMOP_LW, cyc + 1);
    push_ack(1'b0, exp_data, cyc + LAT1 + 2);
    bus1.if_addr = addr;
    bus1.if_req  = 1'b1;
    wait_ack(1'b0, ok);
    check1("if_ack_seen", ok, 1'b1);
    @(posedge clock);
    #1 bus1.if_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] memop, input logic [31:0] exp_rdata);
    bit ok;
    @(negedge clock);
    push_mem(addr, we, wdata, memop, cyc + 1);
    push_ack(1'b1, exp_rdata, we ? cyc + 2 : cyc + LAT1 + 2);
    bus1.d_we    = we;
    bus1.d_addr  = addr;
    bus1.d_wdata = wdata;
    bus1.d_memop = memop;
    bus1.d_req   = 1'b1;
    wait_ack(1'b1, ok);
    check1("d_ack_seen", ok, 1'b1);
    @(posedge clock);
    #1 bus1.d_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check1("rst_if_ack", bus1.if_ack, 1'b0);
    check1("rst_d_ack", bus1.d_ack, 1'b0);
    check1("rst_mem_en", bus1.mem_en, 1'b0);
    check1("rst_mem_we", bus1.mem_we, 1'b0);
    check1("rst_busy", bus1.busy, 1'b0);
    check("rst_mem_addr", bus1.mem_addr, 32'h0);
    check("rst_mem_wdata", bus1.mem_wdata, 32'h0);
    check("rst_mem_memop", 32'(bus1.mem_memop), 32'h0);
    check("rst_if_rdata", bus1.if_rdata, 32'h0);
    check("rst_d_rdata", bus1.d_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en0;
    int ack0;
    bit ok;
    bit okd;
    bit oki;
    bus1.if_req = 1'b0; bus1.if_addr = '0;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_memop = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0;
    bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0; bus3.d_memop = '0;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    check1("rst_lat3_busy", bus3.busy, 1'b0);
    reset = 1'b0;

    // First contention after reset: expect D, IF, D, IF.
    @(negedge clock);
    push_mem(32'h200, 1'b0, 32'h0, MEMOP_LW, -1);
    push_mem(32'h010, 1'b0, 32'h0, MEMOP_LW, -1);
    push_mem(32'h104, 1'b1, 32'hCAFE_F00D, MEMOP_LH, -1);
    push_mem(32'h104, 1'b0, 32'h0, MEMOP_LW, -1);
    push_ack(1'b1, 32'h1234_5678, -1);
    push_ack(1'b1, 32'h1234_5678, -1);
    push_ack(1'b0, 32'h0050_0093, -1);
    push_ack(1'b0, 32'hCAFE_F00D, -1);
    ack_log.delete();
    bus1.if_addr = 32'h10;
    bus1.d_we = 1'b0; bus1.d_addr = 32'h200; bus1.d_memop = MEMOP_LW;
    bus1.if_req = 1'b1;
    bus1.d_req = 1'b1;
    fork
      begin
        wait_ack(1'b1, okd);
        check1("cont_d1_ack_seen", okd, 1'b1);
        @(posedge clock);
        #1;
        bus1.d_we = 1'b1; bus1.d_addr = 32'h104; bus1.d_wdata = 32'hCAFE_F00D; bus1.d_memop = MEMOP_LH;
        wait_ack(1'b1, okd);
        check1("cont_d2_ack_seen", okd, 1'b1);
        @(posedge clock);
        #1 bus1.d_req = 1'b0;
      end
      begin
        wait_ack(1'b0, oki);
        check1("cont_if1_ack_seen", oki, 1'b1);
        @(posedge clock);
        #1 bus1.if_addr = 32'h104;
        wait_ack(1'b0, oki);
        check1("cont_if2_ack_seen", oki, 1'b1);
        @(posedge clock);
        #1 bus1.if_req = 1'b0;
      end
    join
    check("cont_ack_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < ack_log.size(); i++) begin
      check1("cont_ack_order", ack_log[i], (i % 2) == 0);
    end
    @(negedge clock);
    check1("cont_busy_low", bus1.busy, 1'b0);
    @(negedge clock);
    check1("cont_busy_stays_low", bus1.busy, 1'b0);

    fetch(32'h10, 32'h0050_0093);
    d_access(1'b1, 32'h100, 32'hDEAD_BEEF, MEMOP_LW, 32'h1234_5678);
    d_access(1'b0, 32'h100, 32'h0, MEMOP_LW, 32'hDEAD_BEEF);

    en0 = en_count;
    ack0 = ack_count;
    fetch(32'h104, 32'hCAFE_F00D);
    d_access(1'b0, 32'h104, 32'h0, MEMOP_LBU, 32'hCAFE_F00D);
    check("hold_mem_en_count", 32'(en_count - en0), 32'd2);
    check("hold_ack_count", 32'(ack_count - ack0), 32'd2);

    // MEM_LAT=3 load: ack 5 cycles after the sampling edge.
    @(negedge clock);
    begin
      aexp_t a;
      a.data = 32'h1234_5678;
      a.cyc  = cyc + LAT3 + 2;
      d3q.push_back(a);
    end
    bus3.d_we = 1'b0; bus3.d_addr = 32'h200; bus3.d_memop = MEMOP_LW; bus3.d_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus3.d_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check1("lat3_d_ack_seen", ok, 1'b1);
    @(posedge clock);
    #1 bus3.d_req = 1'b0;

    // Reset while a fetch sits in WAIT: abandoned, no ack.
    ack0 = ack_count;
    @(negedge clock);
    push_mem(32'h10, 1'b0, 32'h0, MEMOP_LW, cyc + 1);
    bus1.if_addr = 32'h10;
    bus1.if_req = 1'b1;
    @(negedge clock);
    check1("rw_access_en", bus1.mem_en, 1'b1);
    @(negedge clock);
    check1("rw_busy_in_wait", bus1.busy, 1'b1);
    reset = 1'b1;
    bus1.if_req = 1'b0;
    @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("rw_no_ack", 32'(ack_count - ack0), 32'd0);
    fetch(32'h10, 32'h0050_0093);

    repeat (3) @(negedge clock);
    check("mem_queue_drained", 32'(mq.size()), 32'd0);
    check("if_queue_drained", 32'(ifq.size()), 32'd0);
    check("d_queue_drained", 32'(dq.size()), 32'd0);
    check("lat3_queue_drained", 32'(d3q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the CPU instruction-fetch port (read-only) and the CPU data port (load/store with MemOp).
- Serialises the two requesters with a req/ack handshake and alternating priority.
- Latches each transaction, sequences enable, wait and acknowledge, and returns read data on the granted port.
- Sits between the cpu core and the unified memory in the multi-cycle / shared-memory build.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 1, RAM read latency in cycles, counted from the mem_en cycle to mem_rdata valid; legal range 1..4.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetched word; valid in the if_ack cycle and held until the next if_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_memop  in  3  access size/sign code, passed through unchanged.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  DATA_W  load data; valid in the d_ack cycle and held until the next load d_ack.
- mem_en  out  1  RAM access strobe, exactly one cycle per transaction.
- mem_we  out  1  RAM write enable; high only together with mem_en.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_memop  out  3  latched MemOp; 3'b010 (word) for fetches.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE and last_grant to IF.
  - All outputs go to 0: if_ack, d_ack, mem_en, mem_we, busy, mem_addr, mem_wdata, mem_memop, if_rdata, d_rdata.
  - Reset mid-transaction abandons it silently: no ack, and an in-flight read result is discarded.
- FSM states: IDLE, ACCESS, WAIT, DONE.
  - IDLE:
    - Samples the requests. If only one is high, grant it. If both are high, grant the port that is not last_grant; the first contention after reset therefore goes to data.
    - On grant: latch addr, wdata, memop and we into the mem_* registers (fetch forces we=0, memop=3'b010). Record the grantee and update last_grant. Go to ACCESS.
  - ACCESS (1 cycle):
    - mem_en=1; mem_we = latched we.
    - Store: go to DONE.
    - Load or fetch: load the latency counter with MEM_LAT-1 and go to WAIT.
  - WAIT:
    - Decrement the counter each cycle.
    - In the cycle the counter reads 0, mem_rdata is valid. At that edge, capture it into if_rdata or d_rdata (according to the grantee) and go to DONE.
  - DONE (1 cycle):
    - Pulse the grantee's ack. Go to IDLE.
    - Requests are not sampled in DONE, so a req still high in the ack cycle is never re-granted.
- Latency, counted from the req-sampling edge in IDLE (cycle 0):
  - mem_en is high in cycle 1.
  - Read ack in cycle MEM_LAT+2; store ack in cycle 2.
  - The earliest next grant is sampled in the cycle after ack.
- if_ack and d_ack are never high in the same cycle. mem_en is never high for two consecutive cycles.
- A requester that drops req before its ack is illegal. The transaction still completes and the ack still pulses (transactions are not cancellable).
- A request arriving while busy waits. Its payload must stay stable; the arbiter reads it only at the grant edge.
- Store: mem_rdata is ignored; d_rdata is left unchanged.
- Starvation bound: with both ports requesting continuously, grants alternate strictly D, IF, D, IF, …
- Addresses and data pass through unmodified; no alignment checking is done here.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, DONE);
  - the grantee enum (GNT_IF, GNT_D);
  - MemOp constants, which are the same codes the core drives: MEMOP_LB=3'b000, MEMOP_LH=3'b001, MEMOP_LW=3'b010, MEMOP_LBU=3'b100, MEMOP_LHU=3'b101.
- One sub-module, rr_pick2: combinational two-requester picker. Inputs: req_a, req_b, last. Output: grant, one-hot. It is reused later for the I/O bus.

Test Plan:
- MEM_LAT=1, reset released, if_req=1 with if_addr=0x00000010, RAM word 0x00500093:
  - mem_en is high in cycle 1 with mem_addr=0x10 and mem_memop=3'b010;
  - if_ack is high in cycle 3 with if_rdata=0x00500093;
  - no d_ack occurs.
- Store d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_memop=3'b010:
  - mem_en=1 and mem_we=1 in cycle 1;
  - d_ack in cycle 2;
  - a following load of 0x100 returns 0xDEADBEEF in d_rdata.
- if_req and d_req rise together and both stay high for 4 transactions:
  - acks come in order d, if, d, if;
  - there are never two acks in one cycle;
  - busy drops only once all requests are gone.
- MEM_LAT=3, load from 0x200 holding 0x12345678: d_ack arrives exactly 5 cycles after the sampling edge with d_rdata=0x12345678.
- Reset asserted during WAIT of a fetch:
  - the next cycle has state IDLE and all outputs 0;
  - no if_ack occurs;
  - a later re-issued fetch completes normally.
- Requester holds req high through the ack cycle and drops it the cycle after: exactly one mem_en and one ack per transaction, with no duplicate grant.
